// File: rtl/core_pkg.sv
// core_pkg: shared arbiter state encoding and grant-select constants
package core_pkg;
  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} arb_state_t;
  localparam logic SEL_I = 1'b0;
  localparam logic SEL_D = 1'b1;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch/LSU requester and unified memory port signals; slave = arbiter side, master = environment side
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic                  i_req;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  i_done;
  logic [DATA_WIDTH-1:0] i_rdata;
  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_done;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ready;
  logic                  sel;
  logic                  timeout_err;
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output i_done, i_rdata, d_done, d_rdata, mem_req, mem_we, mem_addr, mem_wdata, sel, timeout_err
  );
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  i_done, i_rdata, d_done, d_rdata, mem_req, mem_we, mem_addr, mem_wdata, sel, timeout_err
  );
endinterface

// File: rtl/mux2.sv
// mux2: two-input select; in0 when sel=0, in1 when sel=1
module mux2 #(
  parameter int WIDTH = 1
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] y
);
  assign y = sel ? in1 : in0;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the unified memory port between fetch (I) and load/store (D) with a grant watchdog
// Ports: clk, rst (asynchronous, active-high); bus (mem_port_arbiter_if.slave) carries requester and memory signals.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise D has fixed priority over I.
module mem_port_arbiter
  import core_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int TIMEOUT    = 255
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  arb_state_t    state_q, state_d;
  logic          sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          granted, timed_out, pick_d;
`ifdef MEM_ARB_RR_EN
  logic last_q, last_d;
  // D wins a tie only when I was served last
  always_comb begin
    pick_d = bus.d_req && (!bus.i_req || last_q == SEL_I);
    last_d = (state_q == IDLE && (bus.d_req || bus.i_req)) ? pick_d : last_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) last_q <= SEL_I;
    else last_q <= last_d;
`else
  assign pick_d = bus.d_req;
`endif
  always_comb begin
    granted   = state_q != IDLE;
    // a completion on the final watchdog cycle takes precedence over the abort
    timed_out = granted && !bus.mem_ready && cnt_q == CW'(TIMEOUT - 1);
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    if (state_q == IDLE) begin
      if (bus.d_req || bus.i_req) begin
        state_d = pick_d ? GRANT_D : GRANT_I;
        sel_d   = pick_d ? SEL_D : SEL_I;
        cnt_d   = '0;
      end
    end else if (bus.mem_ready || timed_out) state_d = IDLE;
    else cnt_d = cnt_q + CW'(1);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= SEL_I;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  mux2 #(.WIDTH(ADDR_WIDTH)) u_addr_mux (
    .sel(sel_q),
    .in0(bus.i_addr),
    .in1(bus.d_addr),
    .y  (bus.mem_addr)
  );
  assign bus.sel         = sel_q;
  assign bus.mem_req     = granted;
  assign bus.mem_we      = state_q == GRANT_D && bus.d_we;
  assign bus.mem_wdata   = state_q == GRANT_D ? bus.d_wdata : {DATA_WIDTH{1'b0}};
  assign bus.i_done      = state_q == GRANT_I && bus.mem_ready;
  assign bus.d_done      = state_q == GRANT_D && bus.mem_ready;
  assign bus.timeout_err = timed_out;
  assign bus.i_rdata     = bus.mem_rdata;
  assign bus.d_rdata     = bus.mem_rdata;
  // requesters must hold req for the whole grant
  a_i_held: assert property (@(posedge clk) disable iff (rst) state_q == GRANT_I |-> bus.i_req);
  a_d_held: assert property (@(posedge clk) disable iff (rst) state_q == GRANT_D |-> bus.d_req);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with a delay-programmable memory responder
module tb_mem_port_arbiter;
  localparam int TO = 4;
  localparam logic [63:0] MAGIC = 64'hA5A5_0F0F_5A5A_F0F0;
  typedef struct {
    logic [2:0]  flags;
    logic [63:0] addr;
    logic        we;
    logic [63:0] wdata;
    int          lat;
  } exp_t;
  logic clk = 0;
  logic rst = 1;
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   gcyc = 0;
  int   rcnt = 0;
  int   delay = 0;
  logic idle_ready = 0;
  logic auto_drop = 1;
  logic [2:0] prev_f = 0;
  mem_port_arbiter_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) bus ();
  mem_port_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    logic [2:0] f;
    exp_t e;
    @(negedge clk);
    gcyc = bus.mem_req ? gcyc + 1 : 0;
    f = {bus.timeout_err, bus.d_done, bus.i_done};
    if (prev_f != 0) check("idle_gap", bus.mem_req, 0);
    if (f != 0) begin
      if (sb.size() == 0) check("unexpected", {61'd0, f}, 0);
      else begin
        e = sb.pop_front();
        check("flags", {61'd0, f}, {61'd0, e.flags});
        check("sel", bus.sel, e.flags[0] ? 64'd0 : 64'd1);
        check("addr", bus.mem_addr, e.addr);
        check("we", bus.mem_we, e.we);
        check("wdata", bus.mem_wdata, e.wdata);
        check("lat", gcyc, e.lat);
        if (!e.flags[2]) check("rdata", e.flags[1] ? bus.d_rdata : bus.i_rdata, e.addr ^ MAGIC);
      end
    end
    prev_f = f;
    @(posedge clk);
    #1;
    if (auto_drop) begin
      if (f[0]) bus.i_req = 0;
      if (f[1]) bus.d_req = 0;
      if (f[2]) begin
        bus.i_req = 0;
        bus.d_req = 0;
      end
    end else if (sb.size() == 0) begin
      bus.i_req = 0;
      bus.d_req = 0;
    end
    if (bus.mem_req) begin
      rcnt++;
      bus.mem_ready = rcnt == delay;
    end else begin
      rcnt = 0;
      bus.mem_ready = idle_ready;
    end
    bus.mem_rdata = bus.mem_addr ^ MAGIC;
  endtask
  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    check("drain", sb.size(), 0);
    tick();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
  initial begin
    bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0;
    bus.d_wdata = 0; bus.mem_rdata = 0; bus.mem_ready = 0;
    #22;
    check("rst_sel", bus.sel, 0);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_flags", {61'd0, bus.timeout_err, bus.d_done, bus.i_done}, 0);
    @(posedge clk);
    #1;
    rst = 0;
    // single fetch
    delay = 3;
    sb.push_back('{3'b001, 64'h100, 1'b0, 64'h0, 3});
    bus.i_addr = 64'h100;
    bus.i_req = 1;
    wait_drain();
    // simultaneous requests: store first, then fetch after an idle cycle
    delay = 2;
    sb.push_back('{3'b010, 64'h2000, 1'b1, 64'hDEAD, 2});
    sb.push_back('{3'b001, 64'h140, 1'b0, 64'h0, 2});
    bus.d_we = 1; bus.d_addr = 64'h2000; bus.d_wdata = 64'hDEAD; bus.i_addr = 64'h140;
    bus.i_req = 1; bus.d_req = 1;
    wait_drain();
    // watchdog abort
    delay = 0;
    sb.push_back('{3'b100, 64'h5000, 1'b1, 64'hBEEF, TO});
    bus.d_we = 1; bus.d_addr = 64'h5000; bus.d_wdata = 64'hBEEF;
    bus.d_req = 1;
    wait_drain();
    // ready on the timeout cycle completes normally
    delay = TO;
    sb.push_back('{3'b010, 64'h5008, 1'b0, 64'h77, TO});
    bus.d_we = 0; bus.d_addr = 64'h5008; bus.d_wdata = 64'h77;
    bus.d_req = 1;
    wait_drain();
    // ready while idle is ignored
    idle_ready = 1;
    tick();
    tick();
    check("idle_ready_flags", {61'd0, bus.timeout_err, bus.d_done, bus.i_done}, 0);
    check("idle_ready_req", bus.mem_req, 0);
    idle_ready = 0;
    tick();
    // asynchronous reset in the middle of a load
    delay = 0;
    bus.d_we = 0; bus.d_addr = 64'h3000;
    bus.d_req = 1;
    tick();
    tick();
    check("pre_rst_req", bus.mem_req, 1);
    #2;
    rst = 1;
    #1;
    check("rst_async_req", bus.mem_req, 0);
    check("rst_async_done", bus.d_done, 0);
    check("rst_async_sel", bus.sel, 0);
    bus.d_req = 0;
    bus.i_addr = 64'h180;
    bus.i_req = 1;
    delay = 2;
    rcnt = 0;
    bus.mem_ready = 0;
    sb.push_back('{3'b001, 64'h180, 1'b0, 64'h0, 2});
    @(posedge clk);
    #1;
    rst = 0;
    wait_drain();
    // both requests held for four transactions
    delay = 1;
    auto_drop = 0;
    bus.i_addr = 64'h600; bus.d_addr = 64'h700; bus.d_we = 0; bus.d_wdata = 64'h11;
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
      if (k % 2 == 0) sb.push_back('{3'b010, 64'h700, 1'b0, 64'h11, 1});
      else sb.push_back('{3'b001, 64'h600, 1'b0, 64'h0, 1});
`else
      sb.push_back('{3'b010, 64'h700, 1'b0, 64'h11, 1});
`endif
    end
    bus.i_req = 1;
    bus.d_req = 1;
    wait_drain();
    auto_drop = 1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
